// File: rtl/led_pkg.sv
// Shared mode encodings and field widths for the LED pattern engine.
package led_pkg;

    localparam int MODE_W  = 3;
    localparam int SPEED_W = 2;

    localparam logic [MODE_W-1:0] MODE_SHIFT_R = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHIFT_L = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BOUNCE  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_COUNT   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd4;
    // Never a legal effective mode, so the first clock after reset always reloads.
    localparam logic [MODE_W-1:0] MODE_RESET   = 3'd7;

    function automatic logic [MODE_W-1:0] eff_mode_f(input logic [MODE_W-1:0] m);
        return (m > MODE_BLINK) ? MODE_SHIFT_R : m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts enabled cycles and raises tick (combinational) on
// the cycle whose edge will wrap the counter; clr restarts the count.
module led_tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             term;

    // >= so a divider shrinking below the live count wraps immediately.
    assign term = (cnt >= div - CNT_W'(1));
    assign tick = en & ~clr & term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= term ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick advancing a runtime-selected pattern.
// Optional LED_PWM_EN adds a 4-bit brightness input with registered PWM gating.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int STEP_DIV = 62500000,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [MODE_W-1:0]  mode,
    input  logic [SPEED_W-1:0] speed,
`ifdef LED_PWM_EN
    input  logic [3:0]         brightness,
`endif
    output logic [N_LEDS-1:0]  led_out,
    output logic               tick
);

    localparam logic [CNT_W-1:0]  DIV0    = CNT_W'(STEP_DIV);
    localparam logic [N_LEDS-1:0] MSB_HOT = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] LSB_HOT = N_LEDS'(1);

    logic [MODE_W-1:0] mode_q, eff_mode;
    logic [CNT_W-1:0]  div_sh, div;
    logic [N_LEDS-1:0] pattern, init_pat, adv_pat;
    logic              dir_left, dir_nxt;
    logic              load, step;

    assign eff_mode = eff_mode_f(mode);
    assign load     = (eff_mode != mode_q);
    assign div_sh   = DIV0 >> speed;
    assign div      = (div_sh == '0) ? CNT_W'(1) : div_sh;

    led_tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .div   (div),
        .tick  (step)
    );

    always_comb begin
        init_pat = '0;
        case (eff_mode)
            MODE_SHIFT_R, MODE_BOUNCE: init_pat = MSB_HOT;
            MODE_SHIFT_L:              init_pat = LSB_HOT;
            default:                   init_pat = '0;
        endcase
    end

    always_comb begin
        adv_pat = pattern;
        dir_nxt = dir_left;
        case (mode_q)
            MODE_SHIFT_R: adv_pat = {pattern[0], pattern[N_LEDS-1:1]};
            MODE_SHIFT_L: adv_pat = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
            MODE_BOUNCE: begin
                // Turn around as soon as an end is reached so it is lit for one step only.
                if (dir_left) begin
                    adv_pat = pattern << 1;
                    if (adv_pat[N_LEDS-1]) dir_nxt = 1'b0;
                end else begin
                    adv_pat = pattern >> 1;
                    if (adv_pat[0]) dir_nxt = 1'b1;
                end
            end
            MODE_COUNT:   adv_pat = pattern + N_LEDS'(1);
            MODE_BLINK:   adv_pat = ~pattern;
            default:      adv_pat = pattern;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_RESET;
            pattern  <= '0;
            dir_left <= 1'b0;
            tick     <= 1'b0;
        end else if (load) begin
            mode_q   <= eff_mode;
            pattern  <= init_pat;
            dir_left <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                pattern  <= adv_pat;
                dir_left <= dir_nxt;
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0]        pwm_cnt;
    logic [N_LEDS-1:0] led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= pattern & {N_LEDS{pwm_cnt < brightness}};
        end
    end

    assign led_out = led_q;
`else
    assign led_out = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen against a step-count reference model.
module tb_led_pattern_gen;

    localparam int N  = 8;
    localparam int SD = 4;
    localparam int CW = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [1:0]   speed = 2'd0;
    logic [N-1:0] led_out;
    logic         tick;

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LEDS(N), .STEP_DIV(SD), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .speed   (speed),
        .led_out (led_out),
        .tick    (tick)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: current mode (7 = none loaded), prescaler count, steps since load.
    int m_mode  = 7;
    int m_cnt   = 0;
    int m_phase = 0;
    int m_tick  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_led();
        int ph, pos;
        if (m_mode == 7) return 0;
        case (m_mode)
            0: return 32'h80 >> (m_phase % 8);
            1: return 32'h01 << (m_phase % 8);
            2: begin
                ph  = m_phase % 14;
                pos = (ph <= 7) ? 7 - ph : ph - 7;
                return 32'h1 << pos;
            end
            3: return m_phase % 256;
            default: return (m_phase % 2 == 1) ? 32'hFF : 32'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = 7; m_cnt = 0; m_phase = 0; m_tick = 0;
    endtask

    task automatic model_clk();
        int e, d;
        if (!rst_n) begin
            m_reset();
            return;
        end
        e = (mode > 4) ? 0 : int'(mode);
        d = SD >> speed;
        if (d == 0) d = 1;
        if (e != m_mode) begin
            m_mode = e; m_cnt = 0; m_phase = 0; m_tick = 0;
        end else if (en) begin
            if (m_cnt >= d - 1) begin
                m_cnt = 0; m_tick = 1; m_phase++;
            end else begin
                m_cnt++; m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_clk();
        #1;
        chk({tag, ".led"}, 32'(led_out), exp_led());
        chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic align_cnt(input int target);
        for (int i = 0; i < 8 && m_cnt != target; i++) cyc("align");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.led", 32'(led_out), 32'h0);
        chk("rst.tick", 32'(tick), 32'h0);

        rst_n = 1'b1; en = 1'b1; mode = 3'd0; speed = 2'd0;
        cyc("first_load");
        chk("first_load.val", 32'(led_out), 32'h80);
        run(40, "shift_r");

        align_cnt(3);
        mode = 3'd1;
        cyc("chg_on_tick");
        chk("chg_on_tick.val", 32'(led_out), 32'h01);
        run(12, "shift_l");

        mode = 3'd2;
        run(70, "bounce");

        align_cnt(2);
        speed = 2'd3;
        run(6, "speed_up");

        mode = 3'd3;
        run(262, "count");
        mode = 3'd4;
        run(6, "blink");

        mode = 3'd6;
        run(5, "mode6");
        mode = 3'd0;
        run(5, "mode6_to_0");
        speed = 2'd0;
        run(7, "slow");

        en = 1'b0;
        run(10, "frozen");
        en = 1'b1;
        run(10, "resume");

        @(posedge clk);
        model_clk();
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst.led", 32'(led_out), 32'h0);
        chk("async_rst.tick", 32'(tick), 32'h0);
        run(2, "in_rst");
        rst_n = 1'b1;
        run(10, "post_rst");

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(49) == 0) mode = 3'($urandom_range(7));
            if ($urandom_range(29) == 0) speed = 2'($urandom_range(3));
            en = ($urandom_range(7) != 0);
            rst_n = ($urandom_range(399) != 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine driving an N-wide LED bank from a single board clock. An internal prescaler produces a step tick at a programmable rate. On each tick the pattern advances according to a runtime-selected mode: walking shift in either direction, bounce, binary count or blink. Sits at board top level, between clock input and LED pins; replaces the fixed single-rate shifter.

Parameters:
N_LEDS, 8, LED bank width (>=2)
STEP_DIV, 62500000, clk cycles per step at speed 0 (>=1)
CNT_W, 32, prescaler counter width; must hold STEP_DIV-1

Ports:
clk  in  1  board clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = run; 0 = freeze prescaler and pattern
mode  in  3  0 SHIFT_R, 1 SHIFT_L, 2 BOUNCE, 3 COUNT, 4 BLINK; 5-7 treated as 0
speed  in  2  step rate multiplier, 2^speed
led_out  out  N_LEDS  registered LED drive, 1 = lit
tick  out  1  registered one-cycle pulse per pattern step

Behaviour:
- Reset (async assert, sync release): led_out=0, tick=0, prescaler cnt=0, dir=right, mode_q=7 (sentinel).
- eff_mode = (mode>4) ? 0 : mode. It is compared each cycle against mode_q.
- Effective divider div = STEP_DIV >> speed; if the result is 0, div=1 (tick every enabled cycle).
- Prescaler, when en=1:
  - if cnt >= div-1: cnt<=0, tick<=1
  - else: cnt<=cnt+1, tick<=0
  - The >= comparison means a speed change that lands below the current cnt ticks on the next cycle. No lost or stuck state.
- en=0: cnt holds, tick<=0, led_out holds. Mode load is still allowed.
- Mode load: if eff_mode != mode_q, then next clock: mode_q<=eff_mode, cnt<=0, tick<=0, led_out<=init(eff_mode), dir<=right.
  - Load has priority over a coincident tick; that tick is dropped.
  - The first clock after reset always loads (sentinel).
- init values: SHIFT_R = MSB one-hot; SHIFT_L = LSB one-hot; BOUNCE = MSB one-hot; COUNT = 0; BLINK = all zero.
- On tick (registered), led_out advances:
  - SHIFT_R: rotate right; LSB wraps to MSB. The pattern is never all-zero.
  - SHIFT_L: rotate left; MSB wraps to LSB.
  - BOUNCE: shift in dir. On reaching LSB set dir=left; on reaching MSB set dir=right. Each end is lit for exactly one step. Period = 2*(N_LEDS-1) steps.
  - COUNT: led_out+1 modulo 2^N_LEDS; all-ones wraps to 0.
  - BLINK: bitwise invert (all-on / all-off alternation).
- led_out updates on the same edge tick goes high. Latency from prescaler terminal count to LED change = 1 clk.
- Reset mid-operation returns everything to reset values immediately. The pattern restarts from init of the current mode.

Optional Feature:
LED_PWM_EN:
- Defined: adds input brightness[3:0] and a free-running 4-bit pwm_cnt (resets to 0). Output is led_out = pattern & {N_LEDS{pwm_cnt < brightness}}, registered. brightness=0 gives all dark; 15 gives 15/16 duty. Pattern and tick behaviour are unchanged.
- Undefined: no brightness port; led_out = pattern register.

Decomposition:
- Package led_pkg: mode localparams (MODE_SHIFT_R..MODE_BLINK), MODE_W=3, SPEED_W=2, sentinel MODE_RESET=7.
- Sub-module led_tick_gen: prescaler with ports clk, rst_n, en, clr, div, tick. clr is driven by mode load.

Test Plan:
- N_LEDS=8, STEP_DIV=4, speed=0, mode=0, en=1 after reset -> led_out 0x80 on first clk, then 0x40,0x20,...,0x01,0x80; tick every 4 clks, no zero step.
- mode=2 BOUNCE -> sequence 0x80,0x40..0x01,0x02..0x80,0x40; 14-step period; each end held exactly one step.
- mode=3, preload by running 255 ticks -> 0xFF then 0x00. mode=4 -> 0x00,0xFF,0x00 per tick.
- speed 0->3 with cnt=3, STEP_DIV=4 (div becomes 1) -> tick next cycle, then every cycle. STEP_DIV=4, speed=3 from reset -> tick every clk.
- Mode change 0->1 on the same cycle as tick -> led_out=0x01 next clk, tick stays 0, next tick 4 clks later. mode=6 -> behaves as SHIFT_R, and a 6<->0 change triggers no reload.
- en=0 mid-sequence for 10 clks -> led_out and cnt frozen, tick=0. rst_n low asynchronously mid-step -> led_out=0 without a clock edge.
